// File: rtl/slow_access_sched.sv
// Routes each CPU bus cycle to the fast path (Rdy 2 CLK after BACT rise) or the slow bus (Rdy the CLK after SlowAck).
// Stalls on the slow engine via SlowReq/SlowAck with a watchdog abort; holds Throttle for a programmable hold-off afterwards.
module slow_access_sched #(
    parameter int WDOG_W = 12,
    parameter int HOLD_W = 8
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic [3:0] SlowTimeout,
    input  logic       SlowClockGate,
    input  logic       TICK,
    input  logic       SlowAck,
    output logic       SlowReq,
    output logic       Rdy,
    output logic       BErr,
    output logic       Throttle,
    output logic       ClkGateEn
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FAST = 2'd1,
        SLOW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic                bact_r;
    logic [WDOG_W-1:0]   wdog;
    logic [HOLD_W-1:0]   hold;

    logic [5:0]          cs_vec;
    logic [5:0]          slow_en_vec;
    logic                start;
    logic                slow_cls;
    logic [WDOG_W-1:0]   wdog_inc;
    logic                wdog_exp;
    logic [HOLD_W-1:0]   hold_reload;
    logic                hold_drain;
    logic                throttle_nxt;

    assign cs_vec      = {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS};
    assign slow_en_vec = {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd};

    assign start    = BACT && !bact_r;
    assign slow_cls = Throttle || (|(cs_vec & slow_en_vec));

    // Expiry looks at the incremented count so the abort lands exactly
    // 2^WDOG_W-1 cycles after SlowReq rises.
    assign wdog_inc = wdog + 1'b1;
    assign wdog_exp = &wdog_inc;

    assign hold_reload = (SlowTimeout == 4'h0) ? '0
                                               : {SlowTimeout, {(HOLD_W-4){1'b1}}};
    assign hold_drain  = TICK && (hold != '0) && ((state == IDLE) || (state == DONE));

    assign throttle_nxt = (SlowTimeout == 4'hF) || (hold != '0) || (state == SLOW);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state     <= IDLE;
            bact_r    <= 1'b0;
            SlowReq   <= 1'b0;
            Rdy       <= 1'b0;
            BErr      <= 1'b0;
            wdog      <= '0;
            hold      <= '0;
            Throttle  <= 1'b1;
            ClkGateEn <= 1'b0;
        end else begin
            bact_r    <= BACT;
            Rdy       <= 1'b0;
            BErr      <= 1'b0;
            Throttle  <= throttle_nxt;
            ClkGateEn <= SlowClockGate && throttle_nxt;

            if (hold_drain) begin
                hold <= hold - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (slow_cls) begin
                            state   <= SLOW;
                            SlowReq <= 1'b1;
                            wdog    <= '0;
                        end else begin
                            state   <= FAST;
                        end
                    end
                end
                FAST: begin
                    Rdy   <= 1'b1;
                    state <= DONE;
                end
                SLOW: begin
                    wdog <= wdog_inc;
                    // A CPU abort has no cycle left to terminate, so it beats both endings.
                    if (!BACT) begin
                        SlowReq <= 1'b0;
                        hold    <= hold_reload;
                        state   <= IDLE;
                    end else if (SlowAck) begin
                        SlowReq <= 1'b0;
                        Rdy     <= 1'b1;
                        hold    <= hold_reload;
                        state   <= DONE;
                    end else if (wdog_exp) begin
                        SlowReq <= 1'b0;
                        BErr    <= 1'b1;
                        hold    <= hold_reload;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!BACT) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slow_access_sched.sv
// Directed bench for slow_access_sched: fast/slow classification, hold-off throttle, watchdog, abort and reset.
module tb_slow_access_sched;

    logic       CLK = 1'b0;
    logic       nPOR = 1'b1;
    logic       BACT = 1'b0;
    logic       IACKCS = 1'b0, VIACS = 1'b0, IWMCS = 1'b0, SCCCS = 1'b0, SCSICS = 1'b0, SndCS = 1'b0;
    logic       SlowIACK = 1'b0, SlowVIA = 1'b0, SlowIWM = 1'b0, SlowSCC = 1'b0, SlowSCSI = 1'b0, SlowSnd = 1'b0;
    logic [3:0] SlowTimeout = 4'h0;
    logic       SlowClockGate = 1'b0;
    logic       TICK = 1'b0;
    logic       SlowAck = 1'b0;
    logic       SlowReq, Rdy, BErr, Throttle, ClkGateEn;

    int errors = 0;
    int checks = 0;

    slow_access_sched #(.WDOG_W(4), .HOLD_W(8)) dut (
        .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
        .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
        .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
        .SlowTimeout(SlowTimeout), .SlowClockGate(SlowClockGate), .TICK(TICK), .SlowAck(SlowAck),
        .SlowReq(SlowReq), .Rdy(Rdy), .BErr(BErr), .Throttle(Throttle), .ClkGateEn(ClkGateEn)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        BACT = 1'b0;
        IACKCS = 1'b0; VIACS = 1'b0; IWMCS = 1'b0; SCCCS = 1'b0; SCSICS = 1'b0; SndCS = 1'b0;
        SlowIACK = 1'b0; SlowVIA = 1'b0; SlowIWM = 1'b0; SlowSCC = 1'b0; SlowSCSI = 1'b0; SlowSnd = 1'b0;
        SlowAck = 1'b0;
        TICK = 1'b0;
    endtask

    // Leaves the bench 1 ns after the first clock edge following release.
    task automatic do_reset(input logic [3:0] timeout, input logic gate);
        clear_inputs();
        SlowTimeout = timeout;
        SlowClockGate = gate;
        nPOR = 1'b0;
        step();
        nPOR = 1'b1;
        step();
    endtask

    task automatic test_reset;
        nPOR = 1'b0;
        #1;
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL reset_slowreq: got %b want 0", SlowReq); end
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", Rdy); end
        checks++; if (BErr !== 1'b0) begin errors++; $display("FAIL reset_berr: got %b want 0", BErr); end
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL reset_throttle: got %b want 1", Throttle); end
        checks++; if (ClkGateEn !== 1'b0) begin errors++; $display("FAIL reset_clkgate: got %b want 0", ClkGateEn); end
    endtask

    task automatic test_forced_throttle;
        do_reset(4'hF, 1'b1);
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL forced_throttle: got %b want 1", Throttle); end
        checks++; if (ClkGateEn !== 1'b1) begin errors++; $display("FAIL forced_clkgate: got %b want 1", ClkGateEn); end
        BACT = 1'b1; VIACS = 1'b1; SlowVIA = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL via_slowreq_rise: got %b want 1", SlowReq); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL via_slowreq_hold[%0d]: got %b want 1", i, SlowReq); end
            checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL via_rdy_early[%0d]: got %b want 0", i, Rdy); end
            checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL via_throttle[%0d]: got %b want 1", i, Throttle); end
        end
        SlowAck = 1'b1;
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL via_rdy: got %b want 1", Rdy); end
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL via_slowreq_drop: got %b want 0", SlowReq); end
        SlowAck = 1'b0;
        step();
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL via_rdy_pulse: got %b want 0", Rdy); end
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL via_throttle_after: got %b want 1", Throttle); end
        clear_inputs();
        step();
    endtask

    task automatic test_fast_path;
        do_reset(4'h0, 1'b0);
        checks++; if (Throttle !== 1'b0) begin errors++; $display("FAIL fast_idle_throttle: got %b want 0", Throttle); end
        BACT = 1'b1; SCCCS = 1'b1;
        step();
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL fast_rdy_early: got %b want 0", Rdy); end
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL fast_slowreq1: got %b want 0", SlowReq); end
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL fast_rdy: got %b want 1", Rdy); end
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL fast_slowreq2: got %b want 0", SlowReq); end
        checks++; if (Throttle !== 1'b0) begin errors++; $display("FAIL fast_throttle: got %b want 0", Throttle); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL fast_no_double[%0d]: got %b want 0", i, Rdy); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_holdoff;
        do_reset(4'h1, 1'b0);
        BACT = 1'b1; IWMCS = 1'b1; SlowIWM = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL iwm_slowreq: got %b want 1", SlowReq); end
        SlowAck = 1'b1;
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL iwm_rdy: got %b want 1", Rdy); end
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL iwm_throttle: got %b want 1", Throttle); end
        clear_inputs();
        step();
        BACT = 1'b1; SCCCS = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL throttled_scc_slowreq: got %b want 1", SlowReq); end
        SlowAck = 1'b1;
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL throttled_scc_rdy: got %b want 1", Rdy); end
        clear_inputs();
        step();
        for (int i = 0; i < 30; i++) begin
            TICK = 1'b1; step();
            TICK = 1'b0; step();
        end
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL hold_30_ticks: got %b want 1", Throttle); end
        TICK = 1'b1; step();
        TICK = 1'b0; step();
        checks++; if (Throttle !== 1'b0) begin errors++; $display("FAIL hold_31_ticks: got %b want 0", Throttle); end
        BACT = 1'b1; SCCCS = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL drained_scc_slowreq: got %b want 0", SlowReq); end
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL drained_scc_rdy: got %b want 1", Rdy); end
        clear_inputs();
        step();
    endtask

    task automatic test_watchdog;
        do_reset(4'h0, 1'b0);
        BACT = 1'b1; SCSICS = 1'b1; SlowSCSI = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL wdog_slowreq_rise: got %b want 1", SlowReq); end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++; if (BErr !== 1'b0) begin errors++; $display("FAIL wdog_berr_early[%0d]: got %b want 0", i, BErr); end
        end
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL wdog_slowreq_held: got %b want 1", SlowReq); end
        step();
        checks++; if (BErr !== 1'b1) begin errors++; $display("FAIL wdog_berr: got %b want 1", BErr); end
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL wdog_slowreq_drop: got %b want 0", SlowReq); end
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL wdog_no_rdy: got %b want 0", Rdy); end
        step();
        checks++; if (BErr !== 1'b0) begin errors++; $display("FAIL wdog_berr_pulse: got %b want 0", BErr); end
        clear_inputs();
        step();

        // SlowAck arrives in the very cycle the watchdog expires.
        do_reset(4'h0, 1'b0);
        BACT = 1'b1; SCSICS = 1'b1; SlowSCSI = 1'b1;
        step();
        repeat (14) step();
        SlowAck = 1'b1;
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL ack_vs_wdog_rdy: got %b want 1", Rdy); end
        checks++; if (BErr !== 1'b0) begin errors++; $display("FAIL ack_vs_wdog_berr: got %b want 0", BErr); end
        clear_inputs();
        step();
    endtask

    task automatic test_abort;
        do_reset(4'h0, 1'b0);
        BACT = 1'b1; VIACS = 1'b1; SlowVIA = 1'b1;
        step();
        step();
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL abort_pre_slowreq: got %b want 1", SlowReq); end
        clear_inputs();
        step();
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL abort_slowreq: got %b want 0", SlowReq); end
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy: got %b want 0", Rdy); end
        checks++; if (BErr !== 1'b0) begin errors++; $display("FAIL abort_berr: got %b want 0", BErr); end
        step();
        BACT = 1'b1; SCCCS = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL post_abort_slowreq: got %b want 0", SlowReq); end
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL post_abort_rdy: got %b want 1", Rdy); end
        clear_inputs();
        step();
    endtask

    task automatic test_multi_cs;
        do_reset(4'h0, 1'b0);
        BACT = 1'b1; SCCCS = 1'b1; SCSICS = 1'b1; SlowSCSI = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL multi_slow_slowreq: got %b want 1", SlowReq); end
        SlowAck = 1'b1;
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL multi_slow_rdy: got %b want 1", Rdy); end
        clear_inputs();
        step();
        // Slow bit of an unselected device must not force the slow path.
        BACT = 1'b1; IACKCS = 1'b1; SndCS = 1'b1; SlowVIA = 1'b1;
        step();
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL multi_fast_slowreq: got %b want 0", SlowReq); end
        step();
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL multi_fast_rdy: got %b want 1", Rdy); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_slow;
        do_reset(4'h0, 1'b1);
        BACT = 1'b1; VIACS = 1'b1; SlowVIA = 1'b1;
        step();
        step();
        checks++; if (SlowReq !== 1'b1) begin errors++; $display("FAIL midrst_pre_slowreq: got %b want 1", SlowReq); end
        nPOR = 1'b0;
        #2;
        checks++; if (SlowReq !== 1'b0) begin errors++; $display("FAIL midrst_slowreq: got %b want 0", SlowReq); end
        checks++; if (Throttle !== 1'b1) begin errors++; $display("FAIL midrst_throttle: got %b want 1", Throttle); end
        clear_inputs();
        @(posedge CLK);
        #1;
        nPOR = 1'b1;
        step();
        checks++; if (Throttle !== 1'b0) begin errors++; $display("FAIL midrst_release_throttle: got %b want 0", Throttle); end
        checks++; if (ClkGateEn !== 1'b0) begin errors++; $display("FAIL midrst_release_clkgate: got %b want 0", ClkGateEn); end
    endtask

    initial begin
        #1;
        test_reset();
        test_forced_throttle();
        test_fast_path();
        test_holdoff();
        test_watchdog();
        test_abort();
        test_multi_cs();
        test_reset_mid_slow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
